// File: rtl/systolic_addr_control.sv
// Read-address sequencer for the systolic matrix-multiply A and B operand buffers.
// A slices advance only on a controller pulse at the pixel wrap; B blocks advance
// on every slice_cntr_B wrap. Counter values are exported for data tagging.
module systolic_addr_control #(
    parameter  int unsigned N1  = 4,
    parameter  int unsigned N2  = 8,
    parameter  int unsigned M   = 16,
    localparam int unsigned WA  = $clog2(M * M / N1),
    localparam int unsigned WB  = $clog2(M * M / N2),
    localparam int unsigned WP  = $clog2(M),
    localparam int unsigned WSA = ((M / N1) > 1) ? $clog2(M / N1) : 1,
    localparam int unsigned WPB = ((M / N2) > 1) ? $clog2(M / N2) : 1
) (
    input  logic           clk,
    input  logic [1:0]     rst,
    input  logic           enable_row_count,
    output logic [WP-1:0]  pixel_cntr_A,
    output logic [WSA-1:0] slice_cntr_A,
    output logic [WPB-1:0] pixel_cntr_B,
    output logic [WP-1:0]  slice_cntr_B,
    output logic [WA-1:0]  rd_addr_A,
    output logic [WB-1:0]  rd_addr_B
);

    localparam int unsigned SA_LAST = (M / N1) - 1;
    localparam int unsigned PB_LAST = (M / N2) - 1;
    localparam int unsigned PX_LAST = M - 1;

    logic [WP-1:0]  pixel_a_q, pixel_a_d;
    logic [WSA-1:0] slice_a_q, slice_a_d;
    logic [WPB-1:0] pixel_b_q, pixel_b_d;
    logic [WP-1:0]  slice_b_q, slice_b_d;

    logic           pixel_a_wrap;
    logic           slice_b_wrap;

    // rst[1] is a staged copy consumed by other blocks; only rst[0] resets here.
    logic           unused_rst_stage;
    assign unused_rst_stage = rst[1];

    assign pixel_a_wrap = (pixel_a_q == WP'(PX_LAST));
    assign slice_b_wrap = (slice_b_q == WP'(PX_LAST));

    // Next-state for all four counters; enable_row_count only matters at the A wrap.
    always_comb begin
        pixel_a_d = pixel_a_q;
        slice_a_d = slice_a_q;
        pixel_b_d = pixel_b_q;
        slice_b_d = slice_b_q;

        pixel_a_d = pixel_a_wrap ? '0 : pixel_a_q + WP'(1);

        if (pixel_a_wrap && enable_row_count) begin
            slice_a_d = (slice_a_q == WSA'(SA_LAST)) ? '0 : slice_a_q + WSA'(1);
        end

        slice_b_d = slice_b_wrap ? '0 : slice_b_q + WP'(1);

        if (slice_b_wrap) begin
            pixel_b_d = (pixel_b_q == WPB'(PB_LAST)) ? '0 : pixel_b_q + WPB'(1);
        end
    end

    // Counter registers with synchronous reset on rst[0].
    always_ff @(posedge clk) begin
        if (rst[0]) begin
            pixel_a_q <= '0;
            slice_a_q <= '0;
            pixel_b_q <= '0;
            slice_b_q <= '0;
        end else begin
            pixel_a_q <= pixel_a_d;
            slice_a_q <= slice_a_d;
            pixel_b_q <= pixel_b_d;
            slice_b_q <= slice_b_d;
        end
    end

    assign pixel_cntr_A = pixel_a_q;
    assign slice_cntr_A = slice_a_q;
    assign pixel_cntr_B = pixel_b_q;
    assign slice_cntr_B = slice_b_q;

    // Addresses are block*M + word; M is a power of two so this is a bit concatenation.
    assign rd_addr_A = WA'({slice_a_q, pixel_a_q});
    assign rd_addr_B = WB'({pixel_b_q, slice_b_q});

endmodule

// File: tb/tb_systolic_addr_control.sv
// Directed self-checking bench for systolic_addr_control at M=16, N1=4, N2=8.
module tb_systolic_addr_control;

    logic       clk;
    logic [1:0] rst;
    logic       enable_row_count;
    logic [3:0] pixel_cntr_A;
    logic [1:0] slice_cntr_A;
    logic [0:0] pixel_cntr_B;
    logic [3:0] slice_cntr_B;
    logic [5:0] rd_addr_A;
    logic [4:0] rd_addr_B;

    int checks   = 0;
    int failures = 0;

    systolic_addr_control #(.N1(4), .N2(8), .M(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_row_count (enable_row_count),
        .pixel_cntr_A     (pixel_cntr_A),
        .slice_cntr_A     (slice_cntr_A),
        .pixel_cntr_B     (pixel_cntr_B),
        .slice_cntr_B     (slice_cntr_B),
        .rd_addr_A        (rd_addr_A),
        .rd_addr_B        (rd_addr_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".pixel_cntr_A"}, int'(pixel_cntr_A), 0);
        check_eq({tag, ".slice_cntr_A"}, int'(slice_cntr_A), 0);
        check_eq({tag, ".pixel_cntr_B"}, int'(pixel_cntr_B), 0);
        check_eq({tag, ".slice_cntr_B"}, int'(slice_cntr_B), 0);
        check_eq({tag, ".rd_addr_A"},    int'(rd_addr_A),    0);
        check_eq({tag, ".rd_addr_B"},    int'(rd_addr_B),    0);
    endtask

    // Expected outputs c cycles after the last reset edge, given current A slice sa.
    task automatic check_cycle(input string tag, input int c, input int sa);
        check_eq($sformatf("%s.pixel_cntr_A@%0d", tag, c), int'(pixel_cntr_A), c % 16);
        check_eq($sformatf("%s.slice_cntr_B@%0d", tag, c), int'(slice_cntr_B), c % 16);
        check_eq($sformatf("%s.pixel_cntr_B@%0d", tag, c), int'(pixel_cntr_B), (c / 16) % 2);
        check_eq($sformatf("%s.slice_cntr_A@%0d", tag, c), int'(slice_cntr_A), sa);
        check_eq($sformatf("%s.rd_addr_A@%0d",    tag, c), int'(rd_addr_A),    sa * 16 + c % 16);
        check_eq($sformatf("%s.rd_addr_B@%0d",    tag, c), int'(rd_addr_B),    c % 32);
    endtask

    // Reset sequence 11 -> 01 -> 00; returns at cycle 0 of a fresh run.
    task automatic do_reset(input string tag);
        rst = 2'b11;
        step();
        check_zero({tag, ".rst11"});
        rst = 2'b01;
        step();
        check_zero({tag, ".rst01"});
        rst = 2'b00;
        check_zero({tag, ".c0"});
    endtask

    initial begin
        rst              = 2'b11;
        enable_row_count = 1'b0;
        step();

        // Reset and free run without enable: A repeats 0..15, B walks 0..31 then wraps.
        do_reset("rst");
        for (int c = 0; c <= 32; c++) begin
            check_cycle("free", c, 0);
            if (c < 32) step();
        end

        // Single pulse at pixel 15 in cycle 31 advances to slice 1.
        do_reset("en31");
        for (int c = 0; c < 31; c++) step();
        check_eq("en31.pixel_cntr_A@31", int'(pixel_cntr_A), 15);
        enable_row_count = 1'b1;
        step();
        enable_row_count = 1'b0;
        check_eq("en31.rd_addr_A@32",    int'(rd_addr_A),    16);
        check_eq("en31.slice_cntr_A@32", int'(slice_cntr_A), 1);
        check_eq("en31.pixel_cntr_A@32", int'(pixel_cntr_A), 0);
        check_eq("en31.rd_addr_B@32",    int'(rd_addr_B),    0);

        // Full pass: pulse every 32 cycles at pixel 15; slice wraps 3 -> 0 at cycle 128.
        do_reset("full");
        for (int c = 0; c <= 128; c++) begin
            check_cycle("full", c, (c / 32) % 4);
            if (c < 128) begin
                enable_row_count = ((c % 32) == 31);
                step();
                enable_row_count = 1'b0;
            end
        end

        // Pulse at pixel 7 is ignored and not remembered for the next wrap.
        do_reset("en7");
        for (int c = 0; c <= 40; c++) begin
            check_cycle("en7", c, 0);
            enable_row_count = (c == 7);
            step();
            enable_row_count = 1'b0;
        end

        // rst[1] alone must not disturb the counters.
        do_reset("rst1");
        for (int c = 0; c <= 8; c++) begin
            check_cycle("rst1", c, 0);
            rst = (c >= 4 && c < 8) ? 2'b10 : 2'b00;
            step();
        end
        rst = 2'b00;

        // Mid-run reset at cycle 50 (after one advance), then restart identical to free run.
        do_reset("mid");
        for (int c = 0; c <= 50; c++) begin
            check_cycle("mid", c, (c >= 32) ? 1 : 0);
            if (c < 50) begin
                enable_row_count = (c == 31);
                step();
                enable_row_count = 1'b0;
            end
        end
        rst = 2'b01;
        step();
        check_zero("mid.rst");
        rst = 2'b00;
        for (int c = 0; c <= 32; c++) begin
            check_cycle("restart", c, 0);
            if (c < 32) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
